sdu_cmd_parser: RTL and testbench

- Sequencing controller for the UART byte receiver of the serial debug unit.
- Drains received bytes over a valid/ready handshake and assembles ASCII command lines.
- Line format: one command letter, optional hex argument, CR terminator.
- Presents the decoded command and argument to the debug-unit command executor over a second valid/ready handshake; flags malformed lines and stalled lines.

---
 rtl/sdu_cmd_parser.sv | 140 ++++++++++++++
 tb/tb_sdu_cmd_parser.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdu_cmd_parser.sv
// Serial debug unit command-line parser: assembles "<letter>[hex]\r" lines from
// UART bytes and hands the decoded command to the executor over valid/ready.
module sdu_cmd_parser #(
  parameter int unsigned MAX_DIGITS  = 8,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  d_rx,
  input  logic        vld_rx,
  output logic        rdy_rx,
  output logic [7:0]  cmd,
  output logic [31:0] arg,
  output logic [3:0]  arg_cnt,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {S_IDLE, S_ARG, S_DONE, S_SKIP} state_t;

  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  state_t      state, state_nx;
  logic [7:0]  cmd_nx;
  logic [31:0] arg_nx;
  logic [3:0]  arg_cnt_nx;
  logic        err_nx;
  logic [1:0]  err_code_nx;
  logic [31:0] tcnt, tcnt_nx;

  logic       accept;
  logic       is_upper, is_lower, is_blank, is_hex_num, is_hex_alpha, is_hex;
  logic [3:0] nibble;

  assign rdy_rx  = (state != S_DONE);
  assign cmd_vld = (state == S_DONE);
  assign accept  = vld_rx & rdy_rx;

  assign is_upper     = (d_rx >= 8'h41) && (d_rx <= 8'h5A);
  assign is_lower     = (d_rx >= 8'h61) && (d_rx <= 8'h7A);
  assign is_blank     = (d_rx == 8'h20) || (d_rx == 8'h0A);
  assign is_hex_num   = (d_rx >= 8'h30) && (d_rx <= 8'h39);
  assign is_hex_alpha = ((d_rx >= 8'h41) && (d_rx <= 8'h46)) ||
                        ((d_rx >= 8'h61) && (d_rx <= 8'h66));
  assign is_hex       = is_hex_num | is_hex_alpha;
  // Letters A-F/a-f share the low nibble 1..6, so +9 yields 10..15.
  assign nibble       = is_hex_num ? d_rx[3:0] : d_rx[3:0] + 4'd9;

  always_comb begin
    state_nx    = state;
    cmd_nx      = cmd;
    arg_nx      = arg;
    arg_cnt_nx  = arg_cnt;
    err_nx      = 1'b0;
    err_code_nx = err_code;
    tcnt_nx     = tcnt;
    case (state)
      S_IDLE: begin
        tcnt_nx = '0;
        if (accept && !(is_blank || d_rx == 8'h0D)) begin
          if (is_upper || is_lower) begin
            cmd_nx     = is_lower ? d_rx - 8'h20 : d_rx;
            arg_nx     = '0;
            arg_cnt_nx = '0;
            state_nx   = S_ARG;
          end else begin
            err_nx      = 1'b1;
            err_code_nx = 2'd1;
            state_nx    = S_SKIP;
          end
        end
      end
      S_ARG, S_SKIP: begin
        if (accept) begin
          tcnt_nx = '0;
          if (state == S_SKIP) begin
            if (d_rx == 8'h0D) state_nx = S_IDLE;
          end else if (is_hex) begin
            if (arg_cnt < MAXD) begin
              arg_nx     = {arg[27:0], nibble};
              arg_cnt_nx = arg_cnt + 4'd1;
            end else begin
              err_nx      = 1'b1;
              err_code_nx = 2'd2;
              state_nx    = S_SKIP;
            end
          end else if (d_rx == 8'h08) begin
            if (arg_cnt != '0) begin
              arg_nx     = arg >> 4;
              arg_cnt_nx = arg_cnt - 4'd1;
            end else begin
              state_nx = S_IDLE;
            end
          end else if (d_rx == 8'h0D) begin
            state_nx = S_DONE;
          end else if (!is_blank) begin
            err_nx      = 1'b1;
            err_code_nx = 2'd3;
            state_nx    = S_SKIP;
          end
        end else if (tcnt == TIMEOUT_CYC - 32'd1) begin
          err_nx      = 1'b1;
          err_code_nx = 2'd0;
          state_nx    = S_IDLE;
          tcnt_nx     = '0;
        end else begin
          tcnt_nx = tcnt + 32'd1;
        end
      end
      S_DONE: begin
        tcnt_nx = '0;
        if (cmd_rdy) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cmd      <= '0;
      arg      <= '0;
      arg_cnt  <= '0;
      err      <= 1'b0;
      err_code <= '0;
      tcnt     <= '0;
    end else begin
      state    <= state_nx;
      cmd      <= cmd_nx;
      arg      <= arg_nx;
      arg_cnt  <= arg_cnt_nx;
      err      <= err_nx;
      err_code <= err_code_nx;
      tcnt     <= tcnt_nx;
    end
  end

endmodule

// File: tb/tb_sdu_cmd_parser.sv
// Randomised bench for sdu_cmd_parser against a line-level reference model
// (digit queue, time-of-last-activity timeout).
module tb_sdu_cmd_parser;

  localparam int unsigned MAXD = 8;
  localparam int unsigned TO   = 100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  d_rx = 8'h00;
  logic        vld_rx = 1'b0;
  logic        rdy_rx;
  logic [7:0]  cmd;
  logic [31:0] arg;
  logic [3:0]  arg_cnt;
  logic        cmd_vld;
  logic        cmd_rdy = 1'b0;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  sdu_cmd_parser #(.MAX_DIGITS(MAXD), .TIMEOUT_CYC(32'(TO))) dut (
    .clk(clk), .rstn(rstn), .d_rx(d_rx), .vld_rx(vld_rx), .rdy_rx(rdy_rx),
    .cmd(cmd), .arg(arg), .arg_cnt(arg_cnt), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .err(err), .err_code(err_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_LINE, M_PENDING, M_DISCARD} mphase_t;
  mphase_t        m_phase = M_IDLE;
  byte unsigned   digits[$];
  logic [7:0]     m_cmd = 8'h00;
  int             m_code = 0;
  bit             m_err = 1'b0;
  longint         cyc = 0;
  longint         last_evt = 0;

  function automatic logic [31:0] arg_value();
    logic [31:0] acc = '0;
    foreach (digits[i]) acc = acc * 16 + 32'(digits[i]);
    return acc;
  endfunction

  function automatic int hex_of(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  task automatic model_step(input logic vld, input logic [7:0] b, input logic crdy);
    bit acc;
    m_err = 1'b0;
    acc = vld && (m_phase != M_PENDING);
    if (acc) last_evt = cyc;
    case (m_phase)
      M_IDLE: if (acc && !(b == 8'h20 || b == 8'h0D || b == 8'h0A)) begin
        if ((b >= "A" && b <= "Z") || (b >= "a" && b <= "z")) begin
          m_cmd = (b >= "a") ? b - 8'h20 : b;
          digits.delete();
          m_phase = M_LINE;
        end else begin
          m_err = 1'b1; m_code = 1; m_phase = M_DISCARD;
        end
      end
      M_LINE: if (acc) begin
        if (hex_of(b) >= 0) begin
          if (digits.size() < MAXD) digits.push_back(byte'(hex_of(b)));
          else begin m_err = 1'b1; m_code = 2; m_phase = M_DISCARD; end
        end else if (b == 8'h08) begin
          if (digits.size() > 0) void'(digits.pop_back());
          else m_phase = M_IDLE;
        end else if (b == 8'h0D) begin
          m_phase = M_PENDING;
        end else if (!(b == 8'h20 || b == 8'h0A)) begin
          m_err = 1'b1; m_code = 3; m_phase = M_DISCARD;
        end
      end
      M_DISCARD: if (acc && b == 8'h0D) m_phase = M_IDLE;
      M_PENDING: if (crdy) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
    if (!acc && (m_phase == M_LINE || m_phase == M_DISCARD) && (cyc - last_evt == longint'(TO))) begin
      m_err = 1'b1; m_code = 0; m_phase = M_IDLE; last_evt = cyc;
    end
  endtask

  // Monitor: advance the model on every rising edge, compare 1 time unit later.
  initial begin
    logic s_vld, s_crdy, s_rstn;
    logic [7:0] s_d;
    forever begin
      @(posedge clk);
      s_vld = vld_rx; s_d = d_rx; s_crdy = cmd_rdy; s_rstn = rstn;
      cyc++;
      if (!s_rstn) begin
        m_phase = M_IDLE; digits.delete(); m_cmd = 8'h00; m_code = 0; m_err = 1'b0;
        last_evt = cyc;
      end else begin
        model_step(s_vld, s_d, s_crdy);
      end
      #1;
      check("err", err, m_err);
      check("err_code", err_code, m_code);
      check("cmd_vld", cmd_vld, m_phase == M_PENDING);
      check("rdy_rx", rdy_rx, m_phase != M_PENDING);
      if (m_phase == M_PENDING || !s_rstn) begin
        check("cmd", cmd, m_cmd);
        check("arg", arg, arg_value());
        check("arg_cnt", arg_cnt, digits.size());
      end
    end
  end

  // cmd_rdy: 0 random, 1 held low, 2 held high
  int crdy_mode = 1;
  initial forever begin
    @(negedge clk);
    if (crdy_mode == 0) cmd_rdy = 1'($urandom_range(0, 1));
    else cmd_rdy = (crdy_mode == 2);
  end

  task automatic set_crdy(input int mode);
    crdy_mode = mode;
    if (mode != 0) cmd_rdy = (mode == 2);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b);
    int w = 0;
    vld_rx = 1'b1;
    d_rx = b;
    while (!rdy_rx && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) check("accept_bound", 32'd0, 32'd1);
    else @(negedge clk);
    vld_rx = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] rand_hex();
    string hx;
    logic [7:0] c;
    hx = "0123456789abcdefABCDEF";
    c = hx[$urandom_range(0, 21)];
    return c;
  endfunction

  initial begin
    idle(3);
    rstn = 1'b1;
    idle(2);

    set_crdy(2);
    send_str("r 1A2b"); send(8'h0D); idle(4);

    set_crdy(1);
    send_str("S"); send(8'h0D);
    idle(20);
    set_crdy(2);
    send_str("N"); send(8'h0D); idle(3);

    send_str("D123456789"); send(8'h0D);
    send_str("G"); send(8'h0D); idle(3);

    send_str("#Wq"); send(8'h0D);
    send_str("Wq"); send(8'h0D); idle(3);

    send_str("M12"); send(8'h08); send_str("F"); send(8'h0D);
    send_str("X"); send(8'h08); send_str("Y"); send(8'h0D); idle(3);

    set_crdy(0);
    send_str("P3"); idle(TO + 10);
    send_str("Q"); idle(TO - 2); send_str("7"); idle(TO - 1); send(8'h0D); idle(4);

    set_crdy(1);
    send_str("K"); send(8'h0D); idle(2);
    #2 rstn = 1'b0;
    #1;
    check("async_cmd_vld", cmd_vld, 1'b0);
    check("async_rdy_rx", rdy_rx, 1'b1);
    idle(2);
    rstn = 1'b1;
    idle(2);

    set_crdy(0);
    repeat (250) begin
      byte unsigned line[$];
      int nd;
      case ($urandom_range(0, 9))
        0: line.push_back(8'($urandom_range(0, 255)));
        1, 2: line.push_back(8'($urandom_range(8'h61, 8'h7A)));
        default: line.push_back(8'($urandom_range(8'h41, 8'h5A)));
      endcase
      nd = $urandom_range(0, 10);
      for (int i = 0; i < nd; i++) begin
        case ($urandom_range(0, 19))
          0: line.push_back(8'h20);
          1: line.push_back(8'h0A);
          2: line.push_back(8'h08);
          3: line.push_back(8'($urandom_range(0, 255)));
          default: line.push_back(rand_hex());
        endcase
      end
      line.push_back(8'h0D);
      foreach (line[i]) begin
        send(line[i]);
        if ($urandom_range(0, 59) == 0) idle(TO - 2 + $urandom_range(0, 2));
        else if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 5));
      end
    end
    set_crdy(2);
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
